instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address fetched first after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, value driven on if_instruction when if_valid=0.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL use these only.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 imem_req  output  1  instruction-memory request, level.
REQ-007 imem_addr  output  32  byte address of request, always equals internal pc.
REQ-008 imem_ready  input  1  memory has imem_rdata for the current imem_addr this cycle.
REQ-009 imem_rdata  input  32  instruction word, valid only when imem_req & imem_ready.
REQ-010 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-011 branch_taken  input  1  decode resolved a taken branch/jump this cycle.
REQ-012 branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-013 if_instruction  output  32  registered instruction presented to decode.
REQ-014 if_pc4  output  32  registered address of if_instruction plus 4.
REQ-015 if_valid  output  1  if_instruction/if_pc4 hold a real instruction.

Function
REQ-016 State machine SHALL have two states: REQ (imem_req=1) and HOLD (imem_req=0, one fetched word parked in skid buffer).
REQ-017 A fetch SHALL complete in any cycle with state REQ and imem_ready=1; zero-wait (ready in the request cycle) and multi-cycle waits SHALL both be supported.
REQ-018 While waiting (REQ, imem_ready=0), pc and imem_addr SHALL remain stable unless branch_taken=1.
REQ-019 Output register "free" SHALL mean if_valid=0 or stall=0.
REQ-020 On completion with output free: if_instruction<=imem_rdata, if_pc4<=pc+4, if_valid<=1, pc<=pc+4, stay REQ.
REQ-021 On completion with output not free (if_valid=1, stall=1): skid<=imem_rdata, skid_pc4<=pc+4, pc<=pc+4, go HOLD.
REQ-022 In HOLD with stall=0: output register<=skid contents with if_valid=1, go REQ; next fetch request issues the following cycle.
REQ-023 In HOLD with stall=1: all state unchanged.
REQ-024 In REQ, no completion, output free: if_valid<=0 (bubble).
REQ-025 In REQ, no completion, stall=1, if_valid=1: output register unchanged.
REQ-026 branch_taken=1 SHALL take priority over stall and completion: pc<=branch_target with bits [1:0] forced to 0, if_valid<=0, skid discarded, state<=REQ; any imem_rdata that cycle is discarded.
REQ-027 First request to branch_target SHALL be presented the cycle after branch_taken; branch penalty is therefore at least one bubble.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-029 When if_valid=0, if_instruction SHALL equal NOP_WORD and if_pc4 SHALL hold its last value.
REQ-030 At most one instruction SHALL be outstanding; no instruction SHALL be lost or duplicated under any stall pattern.

Reset
REQ-031 Asserting reset SHALL immediately force pc=RESET_PC, state=REQ, if_valid=0, if_instruction=NOP_WORD, if_pc4=0, skid cleared, irrespective of clk.
REQ-032 During reset imem_req SHALL be 0; first request at RESET_PC SHALL be asserted in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-wait or in HOLD SHALL abandon the outstanding fetch and parked word without any output pulse.

Verification
REQ-034 Zero-wait stream: imem_ready=1, rdata=addr^32'hA5A5_0000, stall=0 -> if_valid=1 from cycle 2, if_pc4 = 4,8,12,... each cycle, words in order.
REQ-035 Wait states: ready every third cycle -> imem_addr stable during waits, one instruction per completion, bubbles (if_valid=0, NOP_WORD) in between.
REQ-036 Stall into skid: stall=1 for 4 cycles while ready=1 -> output frozen, exactly one word parked, imem_req=0 in HOLD; on release words 0x0,0x4,0x8 appear consecutively without gap or repeat.
REQ-037 Branch during HOLD with stall=1, branch_target=32'h0000_0103 -> next cycle imem_addr=32'h0000_0100, if_valid=0, parked word never emitted.
REQ-038 Wrap: RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc4 for the second fetch = 0.
REQ-039 Asynchronous reset mid-wait (between clock edges) -> if_valid and imem_req drop to 0 before next edge; after release first imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with one-entry skid buffer
//
// Purpose: issues one instruction-memory request at a time from an internal pc,
// registers the returned word for decode, parks one word in a skid buffer when
// decode stalls, and redirects on taken branches.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   imem_req/imem_addr    level request and byte address (always the pc)
//   imem_ready/imem_rdata memory response for the current address
//   stall                 decode cannot accept a new instruction this cycle
//   branch_taken/target   redirect request from decode
//   if_instruction/if_pc4/if_valid  registered output to decode
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc4,
  output logic        if_valid
);

  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic        fetch_done;
  logic        out_free;
  logic [31:0] pc_plus4;

  // Natural 32-bit overflow gives the required wrap at the top of memory.
  assign pc_plus4   = pc_q + 32'd4;
  assign fetch_done = (state_q == S_REQ) && imem_ready;
  assign out_free   = !if_valid_q || !stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc4_d   = if_pc4_q;
    if_valid_d = if_valid_q;
    skid_d     = skid_q;
    skid_pc4_d = skid_pc4_q;

    if (branch_taken) begin
      // Redirect wins over everything; any word returning this cycle is dropped.
      pc_d       = {branch_target[31:2], 2'b00};
      if_valid_d = 1'b0;
      if_instr_d = NOP_WORD;
      skid_d     = 32'd0;
      skid_pc4_d = 32'd0;
      state_d    = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (fetch_done) begin
            pc_d = pc_plus4;
            if (out_free) begin
              if_instr_d = imem_rdata;
              if_pc4_d   = pc_plus4;
              if_valid_d = 1'b1;
            end else begin
              skid_d     = imem_rdata;
              skid_pc4_d = pc_plus4;
              state_d    = S_HOLD;
            end
          end else if (out_free) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_WORD;
          end
        end
        S_HOLD: begin
          // The output register is necessarily valid here, so it frees only on !stall.
          if (!stall) begin
            if_instr_d = skid_q;
            if_pc4_d   = skid_pc4_q;
            if_valid_d = 1'b1;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      if_instr_q <= NOP_WORD;
      if_pc4_q   <= 32'd0;
      if_valid_q <= 1'b0;
      skid_q     <= 32'd0;
      skid_pc4_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc4_q   <= if_pc4_d;
      if_valid_q <= if_valid_d;
      skid_q     <= skid_d;
      skid_pc4_q <= skid_pc4_d;
    end
  end

  // Gating with reset keeps the request low for the whole reset window.
  assign imem_req       = (state_q == S_REQ) && !reset;
  assign imem_addr      = pc_q;
  assign if_instruction = if_instr_q;
  assign if_pc4         = if_pc4_q;
  assign if_valid       = if_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_instruction, if_pc4;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: each word is its own address xor a fixed salt.
  assign imem_rdata = imem_addr ^ SALT;
  assign w_rdata    = w_addr ^ SALT;

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_instruction(if_instruction), .if_pc4(if_pc4), .if_valid(if_valid)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(w_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_instruction(w_instr), .if_pc4(w_pc4), .if_valid(w_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] p4);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".instr"}, if_instruction, ins);
    chk({tag, ".pc4"}, if_pc4, p4);
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0;
    @(negedge clk);
    #1;
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.addr", imem_addr, 32'd0);
    chk_out("rst", 1'b0, NOP, 32'd0);
    chk("rst.waddr", w_addr, 32'hFFFF_FFF8);
    @(negedge clk);

    // Zero-wait stream; wrap instance checked alongside.
    reset = 1'b0;
    #1;
    chk("rel.req", {31'd0, imem_req}, 32'd1);
    chk("rel.addr", imem_addr, 32'd0);
    imem_ready = 1'b1;
    tick();
    chk_out("zw0", 1'b1, 32'h0 ^ SALT, 32'd4);
    chk("zw0.waddr", w_addr, 32'hFFFF_FFFC);
    chk("zw0.wpc4", w_pc4, 32'hFFFF_FFFC);
    tick();
    chk_out("zw1", 1'b1, 32'h4 ^ SALT, 32'd8);
    chk("zw1.waddr", w_addr, 32'h0000_0000);
    chk("zw1.wpc4", w_pc4, 32'h0000_0000);
    chk("zw1.winstr", w_instr, 32'hFFFF_FFFC ^ SALT);
    tick();
    chk_out("zw2", 1'b1, 32'h8 ^ SALT, 32'd12);
    chk("zw2.addr", imem_addr, 32'd12);

    // Wait states: two-cycle wait then completion.
    imem_ready = 1'b0;
    tick();
    chk_out("ws0", 1'b0, NOP, 32'd12);
    chk("ws0.addr", imem_addr, 32'd12);
    tick();
    chk_out("ws1", 1'b0, NOP, 32'd12);
    chk("ws1.addr", imem_addr, 32'd12);
    imem_ready = 1'b1;
    tick();
    chk_out("ws2", 1'b1, 32'hC ^ SALT, 32'd16);
    chk("ws2.addr", imem_addr, 32'd16);

    // Restart from address 0 for the skid sequence.
    reset = 1'b1;
    #1;
    chk("rst2.valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_out("sk0", 1'b1, 32'h0 ^ SALT, 32'd4);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("skh", 1'b1, 32'h0 ^ SALT, 32'd4);
      chk("skh.req", {31'd0, imem_req}, 32'd0);
      chk("skh.addr", imem_addr, 32'd8);
    end
    stall = 1'b0;
    tick();
    chk_out("sk1", 1'b1, 32'h4 ^ SALT, 32'd8);
    chk("sk1.req", {31'd0, imem_req}, 32'd1);
    tick();
    chk_out("sk2", 1'b1, 32'h8 ^ SALT, 32'd12);

    // Branch while holding a parked word.
    stall = 1'b1;
    tick();
    chk("br0.req", {31'd0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    tick();
    chk("br1.addr", imem_addr, 32'h0000_0100);
    chk("br1.req", {31'd0, imem_req}, 32'd1);
    chk_out("br1", 1'b0, NOP, 32'd12);
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    chk_out("br2", 1'b1, 32'h100 ^ SALT, 32'h104);

    // Asynchronous reset while waiting with a valid output held.
    imem_ready = 1'b0; stall = 1'b1;
    tick();
    chk_out("ar0", 1'b1, 32'h100 ^ SALT, 32'h104);
    #2 reset = 1'b1;
    #1;
    chk("ar1.valid", {31'd0, if_valid}, 32'd0);
    chk("ar1.req", {31'd0, imem_req}, 32'd0);
    chk("ar1.instr", if_instruction, NOP);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    #1;
    chk("ar2.addr", imem_addr, 32'd0);
    chk("ar2.req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    chk_out("ar3", 1'b1, 32'h0 ^ SALT, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
